// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch for a 160x144 image shown 3x-scaled in a 480x432 VGA window.
// Optional macro VGA_FETCH_BORDER_EN drives border_color outside the window instead of black.
module vga_pixel_fetch #(
    parameter int H_WIN_START = 224,
    parameter int V_WIN_START = 59
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [9:0]  h_sync_cnt,
    input  logic [9:0]  v_sync_cnt,
    input  logic        vga_hs_in,
    input  logic        vga_vs_in,
    output logic [14:0] fb_addr,
    input  logic [11:0] fb_data,
    input  logic [11:0] border_color,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam logic [9:0]  H_FIRST       = 10'(H_WIN_START);
    localparam logic [9:0]  H_END         = 10'(H_WIN_START + 480);
    localparam logic [9:0]  H_PRE         = 10'(H_WIN_START - 1);
    localparam logic [9:0]  V_FIRST       = 10'(V_WIN_START);
    localparam logic [9:0]  V_END         = 10'(V_WIN_START + 432);
    localparam logic [14:0] LINE_STEP     = 15'd160;
    localparam logic [14:0] LINE_BASE_MAX = 15'd22880;

    logic        w_h_in;
    logic        w_v_in;
    logic        w_in_win;
    logic        w_line_end;
    logic [11:0] w_idle_color;

    logic [1:0]  r_x_sub;
    logic [7:0]  r_x_pix;
    logic [1:0]  r_y_sub;
    logic [14:0] r_line_base;
    logic        r_win_s1;
    logic        r_hs_s1;
    logic        r_vs_s1;

    assign w_h_in     = (h_sync_cnt >= H_FIRST) && (h_sync_cnt < H_END);
    assign w_v_in     = (v_sync_cnt >= V_FIRST) && (v_sync_cnt < V_END);
    assign w_in_win   = w_h_in && w_v_in;
    assign w_line_end = (h_sync_cnt == H_END) && w_v_in;

`ifdef VGA_FETCH_BORDER_EN
    assign w_idle_color = border_color;
`else
    logic w_unused_border;
    assign w_unused_border = ^border_color;
    assign w_idle_color    = 12'h000;
`endif

    // NOTE: reset is synchronous; rst_n is only acted on at a vga_clk edge.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            fb_addr     <= '0;
            r_x_sub     <= '0;
            r_x_pix     <= '0;
            r_y_sub     <= '0;
            r_line_base <= '0;
            r_win_s1    <= 1'b0;
            r_hs_s1     <= 1'b0;
            r_vs_s1     <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b0;
            vga_vs      <= 1'b0;
        end else begin
            // Stage 0: address uses the counters as they stood before this cycle's advance.
            if (w_in_win) begin
                fb_addr <= r_line_base + {7'd0, r_x_pix};
            end

            if (h_sync_cnt == H_PRE) begin
                r_x_sub <= '0;
                r_x_pix <= '0;
            end else if (w_in_win) begin
                if (r_x_sub == 2'd2) begin
                    r_x_sub <= '0;
                    r_x_pix <= (r_x_pix == 8'd159) ? 8'd0 : r_x_pix + 8'd1;
                end else begin
                    r_x_sub <= r_x_sub + 2'd1;
                end
            end

            if (v_sync_cnt == 10'd0) begin
                r_y_sub     <= '0;
                r_line_base <= '0;
            end else if (w_line_end) begin
                if (r_y_sub == 2'd2) begin
                    r_y_sub     <= '0;
                    r_line_base <= (r_line_base >= LINE_BASE_MAX) ? LINE_BASE_MAX
                                                                  : r_line_base + LINE_STEP;
                end else begin
                    r_y_sub <= r_y_sub + 2'd1;
                end
            end

            // NOTE: non-blocking updates make stage 2 see stage 1's previous-cycle contents.
            r_win_s1 <= w_in_win;
            r_hs_s1  <= vga_hs_in;
            r_vs_s1  <= vga_vs_in;

            {vga_r, vga_g, vga_b} <= r_win_s1 ? fb_data : w_idle_color;
            vga_hs <= r_hs_s1;
            vga_vs <= r_vs_s1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: randomized scan patterns against a window-geometry model.
// Honours VGA_FETCH_BORDER_EN for the expected out-of-window colour.
module tb_vga_pixel_fetch;

    localparam int H0 = 224;
    localparam int V0 = 59;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_sync_cnt;
    logic [9:0]  v_sync_cnt;
    logic        vga_hs_in;
    logic        vga_vs_in;
    logic [14:0] fb_addr;
    logic [11:0] fb_data;
    logic [11:0] border_color;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    logic [11:0] mem [0:23039];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          win_lines;
    int          last_addr;
    logic        s1_win;
    int          s1_addr;
    logic        s1_hs;
    logic        s1_vs;
    logic [14:0] e_addr;
    logic [11:0] e_col;
    logic        e_hs;
    logic        e_vs;

    vga_pixel_fetch dut (
        .vga_clk      (vga_clk),
        .rst_n        (rst_n),
        .h_sync_cnt   (h_sync_cnt),
        .v_sync_cnt   (v_sync_cnt),
        .vga_hs_in    (vga_hs_in),
        .vga_vs_in    (vga_vs_in),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .border_color (border_color),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs)
    );

    // Synchronous framebuffer: data for an address is ready during the cycle after it is issued.
    assign fb_data = mem[fb_addr];

    always #5 vga_clk = ~vga_clk;

    function automatic logic [11:0] idle_colour();
`ifdef VGA_FETCH_BORDER_EN
        return border_color;
`else
        return 12'h000;
`endif
    endfunction

    // Drive one cycle of counters and advance the model; e_* hold what the DUT must show now.
    task automatic step(input int h, input int v, input logic hs, input logic vs);
        logic win;
        int   row;
        h_sync_cnt = 10'(h);
        v_sync_cnt = 10'(v);
        vga_hs_in  = hs;
        vga_vs_in  = vs;
        @(posedge vga_clk);
        #1;
        win = (h >= H0) && (h < H0 + 480) && (v >= V0) && (v < V0 + 432);
        if (!rst_n) begin
            win_lines = 0;
            last_addr = 0;
            s1_win = 1'b0; s1_addr = 0; s1_hs = 1'b0; s1_vs = 1'b0;
            e_addr = '0; e_col = '0; e_hs = 1'b0; e_vs = 1'b0;
        end else begin
            e_col = s1_win ? mem[s1_addr] : idle_colour();
            e_hs  = s1_hs;
            e_vs  = s1_vs;
            if (win) begin
                row       = (win_lines / 3 > 143) ? 143 : win_lines / 3;
                last_addr = row * 160 + (h - H0) / 3;
            end
            e_addr = 15'(last_addr);
            if (v == 0)
                win_lines = 0;
            else if (h == H0 + 480 && v >= V0 && v < V0 + 432)
                win_lines++;
            s1_win = win; s1_addr = last_addr; s1_hs = hs; s1_vs = vs;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) begin
            step(300, 59, 1'b1, 1'b1);
            checks++;
            if ({fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs} !== 29'd0) begin
                failures++;
                $display("FAIL reset_init outputs=%h required=0", {fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs});
            end
        end
        rst_n = 1'b1;
        step(0, 0, 1'b0, 1'b0);
        step(223, 59, 1'b0, 1'b0);
        for (int h = 224; h < 300; h++) begin
            step(h, 59, 1'($urandom), 1'($urandom));
            checks++;
            if ({fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {e_addr, e_col, e_hs, e_vs}) begin
                failures++;
                $display("FAIL reset_preline h=%0d addr=%h col=%h hs=%b vs=%b required addr=%h col=%h hs=%b vs=%b",
                         h, fb_addr, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, e_addr, e_col, e_hs, e_vs);
            end
        end
        rst_n = 1'b0;
        repeat (3) begin
            step(300, 59, 1'b1, 1'b1);
            checks++;
            if ({fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs} !== 29'd0) begin
                failures++;
                $display("FAIL reset_midline outputs=%h required=0", {fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs});
            end
        end
        rst_n = 1'b1;
        step(750, 59, 1'b1, 1'b0);
        checks++;
        if ({fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {e_addr, e_col, e_hs, e_vs}) begin
            failures++;
            $display("FAIL reset_release addr=%h col=%h hs=%b vs=%b required addr=%h col=%h hs=%b vs=%b",
                     fb_addr, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, e_addr, e_col, e_hs, e_vs);
        end
    endtask

    task automatic test_first_pixel();
        mem[0] = 12'hABC;
        step(0, 0, 1'b0, 1'b0);
        step(223, 59, 1'b0, 1'b0);
        step(224, 59, 1'b0, 1'b0);
        checks++;
        if (fb_addr !== 15'd0) begin
            failures++;
            $display("FAIL first_pixel_addr addr=%0d required=0", fb_addr);
        end
        step(225, 59, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'hABC) begin
            failures++;
            $display("FAIL first_pixel_colour rgb=%h required=abc", {vga_r, vga_g, vga_b});
        end
    endtask

    task automatic test_h_replication();
        int exp_seq [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        step(0, 0, 1'b0, 1'b0);
        step(223, 59, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(224 + i, 59, 1'b0, 1'b0);
            checks++;
            if (fb_addr !== 15'(exp_seq[i])) begin
                failures++;
                $display("FAIL h_replication h=%0d addr=%0d required=%0d", 224 + i, fb_addr, exp_seq[i]);
            end
        end
    endtask

    task automatic test_v_stepping();
        step(0, 0, 1'b0, 1'b0);
        for (int v = 59; v <= 62; v++) begin
            step(223, v, 1'b0, 1'b0);
            step(224, v, 1'b0, 1'b0);
            checks++;
            if (fb_addr !== ((v == 62) ? 15'd160 : 15'd0)) begin
                failures++;
                $display("FAIL v_stepping v=%0d addr=%0d required=%0d", v, fb_addr, (v == 62) ? 160 : 0);
            end
            step(225, v, 1'b0, 1'b0);
            step(704, v, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random_frame();
        int n;
        step(0, 0, 1'b0, 1'b1);
        for (int v = V0; v < V0 + 432; v++) begin
            if (v == V0 || v == 490 || $urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(0, 3)) step($urandom_range(705, 1023), v, 1'($urandom), 1'($urandom));
                step(223, v, 1'($urandom), 1'($urandom));
                n = (v == 490) ? 480 : $urandom_range(1, 480);
                for (int h = H0; h < H0 + n; h++) begin
                    step(h, v, 1'($urandom), 1'($urandom));
                    checks++;
                    if ({fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {e_addr, e_col, e_hs, e_vs}) begin
                        failures++;
                        $display("FAIL rand_frame h=%0d v=%0d addr=%h col=%h hs=%b vs=%b required addr=%h col=%h hs=%b vs=%b",
                                 h, v, fb_addr, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, e_addr, e_col, e_hs, e_vs);
                    end
                end
                if (v == 490) begin
                    checks++;
                    if (fb_addr !== 15'd23039) begin
                        failures++;
                        $display("FAIL last_pixel addr=%0d required=23039", fb_addr);
                    end
                end
            end
            step(704, v, 1'($urandom), 1'($urandom));
        end
        step(223, 491, 1'b0, 1'b0);
        step(300, 491, 1'b0, 1'b0);
        step(301, 491, 1'b0, 1'b0);
        checks++;
        if ({vga_r, vga_g, vga_b} !== idle_colour()) begin
            failures++;
            $display("FAIL below_window rgb=%h required=%h", {vga_r, vga_g, vga_b}, idle_colour());
        end
    endtask

    // Without a frame restart the window rows run past the framebuffer; the last row repeats.
    task automatic test_clamp();
        for (int v = V0; v < V0 + 6; v++) begin
            step(223, v, 1'b0, 1'b0);
            step(224, v, 1'b0, 1'b0);
            checks++;
            if (fb_addr !== 15'd22880) begin
                failures++;
                $display("FAIL clamp_base v=%0d addr=%0d required=22880", v, fb_addr);
            end
            for (int h = H0 + 1; h < H0 + 40; h++) begin
                step(h, v, 1'b0, 1'b0);
                checks++;
                if ({fb_addr, vga_r, vga_g, vga_b} !== {e_addr, e_col}) begin
                    failures++;
                    $display("FAIL clamp h=%0d v=%0d addr=%h col=%h required addr=%h col=%h",
                             h, v, fb_addr, {vga_r, vga_g, vga_b}, e_addr, e_col);
                end
            end
            step(704, v, 1'b0, 1'b0);
        end
    endtask

    task automatic test_sync_align();
        logic hs_pat [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic vs_pat [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(750, 600, hs_pat[i], vs_pat[i]);
            if (i >= 1) begin
                checks++;
                if ({vga_hs, vga_vs} !== {hs_pat[i - 1], vs_pat[i - 1]}) begin
                    failures++;
                    $display("FAIL sync_align i=%0d hs=%b vs=%b required hs=%b vs=%b",
                             i, vga_hs, vga_vs, hs_pat[i - 1], vs_pat[i - 1]);
                end
            end
        end
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(705, 1023), $urandom_range(492, 1023), 1'($urandom), 1'($urandom));
            checks++;
            if ({vga_hs, vga_vs, vga_r, vga_g, vga_b} !== {e_hs, e_vs, e_col}) begin
                failures++;
                $display("FAIL sync_random hs=%b vs=%b col=%h required hs=%b vs=%b col=%h",
                         vga_hs, vga_vs, {vga_r, vga_g, vga_b}, e_hs, e_vs, e_col);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 23040; i++) mem[i] = 12'($urandom);
        border_color = 12'($urandom) | 12'h001;
        rst_n        = 1'b0;
        h_sync_cnt   = '0;
        v_sync_cnt   = '0;
        vga_hs_in    = 1'b0;
        vga_vs_in    = 1'b0;
        win_lines = 0; last_addr = 0;
        s1_win = 1'b0; s1_addr = 0; s1_hs = 1'b0; s1_vs = 1'b0;
        e_addr = '0; e_col = '0; e_hs = 1'b0; e_vs = 1'b0;

        test_reset();
        test_first_pixel();
        test_h_replication();
        test_v_stepping();
        test_random_frame();
        test_clamp();
        test_sync_align();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 SHALL have parameter H_WIN_START, default 224, meaning the h_sync_cnt value of the first window column.
REQ-002 SHALL have parameter V_WIN_START, default 59, meaning the v_sync_cnt value of the first window line.
REQ-003 SHALL have port vga_clk, input, 1 bit, the pixel clock; the only clock.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port h_sync_cnt, input, 10 bits, horizontal counter from vga_timing.
REQ-006 SHALL have port v_sync_cnt, input, 10 bits, vertical counter from vga_timing.
REQ-007 SHALL have ports vga_hs_in and vga_vs_in, inputs, 1 bit each, syncs from vga_timing.
REQ-008 SHALL have port fb_addr, output, 15 bits, framebuffer read address.
REQ-009 SHALL have port fb_data, input, 12 bits, RGB444 pixel valid one vga_clk after fb_addr.
REQ-010 SHALL have port border_color, input, 12 bits, RGB444 colour outside the window.
REQ-011 SHALL have ports vga_r, vga_g and vga_b, outputs, 4 bits each, registered colour.
REQ-012 SHALL have ports vga_hs and vga_vs, outputs, 1 bit each, syncs aligned to colour.

Function
REQ-013 SHALL map the 160x144 framebuffer to a 480x432 window, 3x3 pixel replication, origin (H_WIN_START, V_WIN_START).
REQ-014 SHALL compute in_win for stage 0 as true when both conditions hold:
- H_WIN_START <= h_sync_cnt < H_WIN_START+480
- V_WIN_START <= v_sync_cnt < V_WIN_START+432
REQ-015 SHALL generate addresses without a multiplier, using these counters:
- x_sub: 0..2
- x_pix: 0..159
- y_sub: 0..2
- line_base: steps by 160
REQ-016 SHALL output fb_addr = line_base + x_pix, registered, in stage 0.
REQ-017 SHALL advance x_sub each in-window cycle; on x_sub==2, x_sub wraps to 0 and x_pix increments.
REQ-018 SHALL clear x_sub and x_pix to 0 when h_sync_cnt == H_WIN_START-1.
REQ-019 SHALL advance y_sub once per window line, at h_sync_cnt == H_WIN_START+480 while inside the vertical window.
REQ-020 SHALL add 160 to line_base on y_sub wrap 2->0.
REQ-021 SHALL clear y_sub and line_base when v_sync_cnt == 0; a frame restart mid-window takes this priority.
REQ-022 SHALL keep fb_addr within 0..23039; if line_base would exceed 22880, it holds at 22880.
REQ-023 SHALL delay in_win, vga_hs_in and vga_vs_in through two register stages.
REQ-024 SHALL register colour in stage 2:
- {vga_r,vga_g,vga_b} = fb_data when delayed in_win is true.
- Otherwise see REQ-029.
REQ-025 SHALL have total latency of 2 vga_clk from counter input to colour/sync output, identical for colour and syncs.
REQ-026 SHALL hold fb_addr at its last value outside the window.

Reset
REQ-027 SHALL, while rst_n==0 at a vga_clk edge, clear these to 0:
- fb_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs
- x_sub, x_pix, y_sub, line_base
- all pipeline stages
REQ-028 SHALL resume at the counter-defined position on the first edge with rst_n==1, with the first frame addresses correct from the next v_sync_cnt==0.

Configuration
REQ-029 SHALL treat macro VGA_FETCH_BORDER_EN as follows:
- Defined: outside the window, colour = border_color.
- Undefined: outside the window, colour = 0 and the border_color input is ignored.

Verification
REQ-030 SHALL cover reset mid-line: rst_n=0 for 3 cycles at h_sync_cnt=300 -> all outputs 0 one cycle later.
REQ-031 SHALL cover the first pixel: counters (224,59), fb_data=12'hABC -> fb_addr=0 one cycle later, {r,g,b}=A,B,C two cycles later.
REQ-032 SHALL cover horizontal replication: line 59, h 224..232 -> fb_addr sequence 0,0,0,1,1,1,2,2,2.
REQ-033 SHALL cover vertical stepping: lines 59,60,61 -> fb_addr at column start = 0; line 62 -> fb_addr at column start = 160.
REQ-034 SHALL cover the last pixel: counters (703,490) -> fb_addr=23039; the next line is outside the window -> colour=0, or border_color when VGA_FETCH_BORDER_EN is defined.
REQ-035 SHALL cover sync alignment: a vga_hs_in rising edge at cycle N -> vga_hs rising edge at cycle N+2.
